// File: rtl/modport_mips.sv
// Multicycle MIPS-subset core: 12-state Moore controller plus datapath.
// Owns the register file, ALU, data memory and the IR/A/B/MDR/ALUOut
// registers. The environment supplies Instr and PC and reads back Next_PC.
module modport_mips (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [31:0] PC,
  output logic [31:0] Next_PC,
  output logic [31:0] ALUResult,
  output logic [31:0] ALUOut,
  output logic [31:0] B,
  output logic        zero,
  output logic [31:0] WD3,
  output logic [4:0]  A3,
  output logic        RegWrite,
  output logic [3:0]  p_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  state_t      r_state, w_next;
  logic [31:0] r_ir, r_a, r_b, r_mdr, r_aluout, r_next_pc;
  logic [31:0] r_rf   [32];
  logic [31:0] r_dmem [64];

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_imm, w_pc4, w_srca, w_srcb, w_alu;
  logic        w_funct_ok;
  alu_op_t     w_alu_op;

  assign w_op    = r_ir[31:26];
  assign w_rs    = r_ir[25:21];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];
  assign w_funct = r_ir[5:0];
  assign w_imm   = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_pc4   = PC + 32'd4;

  assign w_funct_ok = (w_funct == FN_ADD) || (w_funct == FN_SUB) ||
                      (w_funct == FN_AND) || (w_funct == FN_OR)  ||
                      (w_funct == FN_SLT);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state decode; unsupported opcodes/functs fall back to FETCH
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = w_funct_ok ? S_EXECUTE : S_FETCH;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEXEC;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    w_next = S_MEMWB;
      S_EXECUTE:  w_next = S_ALUWB;
      S_ADDIEXEC: w_next = S_ADDIWB;
      default:    w_next = S_FETCH;
    endcase
  end

  // ALU operand/operation selection, decoded from state
  always_comb begin
    w_srca   = r_a;
    w_srcb   = r_b;
    w_alu_op = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_srca = PC;
        w_srcb = 32'd4;
      end
      S_DECODE: begin
        w_srca = w_pc4;
        w_srcb = {w_imm[29:0], 2'b00};
      end
      S_MEMADR, S_ADDIEXEC: w_srcb = w_imm;
      S_EXECUTE: begin
        case (w_funct)
          FN_SUB:  w_alu_op = ALU_SUB;
          FN_AND:  w_alu_op = ALU_AND;
          FN_OR:   w_alu_op = ALU_OR;
          FN_SLT:  w_alu_op = ALU_SLT;
          default: w_alu_op = ALU_ADD;
        endcase
      end
      S_BRANCH: w_alu_op = ALU_SUB;
      default: ;
    endcase
  end

  // ALU core: wraparound arithmetic, signed slt
  always_comb begin
    w_alu = w_srca + w_srcb;
    case (w_alu_op)
      ALU_SUB: w_alu = w_srca - w_srcb;
      ALU_AND: w_alu = w_srca & w_srcb;
      ALU_OR:  w_alu = w_srca | w_srcb;
      ALU_SLT: w_alu = ($signed(w_srca) < $signed(w_srcb)) ? 32'd1 : 32'd0;
      default: ;
    endcase
  end

  assign ALUResult = w_alu;
  assign zero      = (w_alu == 32'd0);

  // Write-back control is purely a function of state
  assign RegWrite = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                    (r_state == S_ADDIWB);
  assign A3       = (r_state == S_ALUWB) ? w_rd : w_rt;
  assign WD3      = (r_state == S_MEMWB) ? r_mdr : r_aluout;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_mdr     <= '0;
      r_aluout  <= '0;
      r_next_pc <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_ir      <= Instr;
          r_next_pc <= w_pc4;
        end
        S_DECODE: begin
          r_a      <= (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
          r_b      <= (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];
          r_aluout <= w_alu;
        end
        S_MEMADR, S_EXECUTE, S_ADDIEXEC: r_aluout <= w_alu;
        S_MEMRD:  r_mdr <= r_dmem[r_aluout[7:2]];
        S_BRANCH: if (zero) r_next_pc <= r_aluout;
        S_JUMP:   r_next_pc <= {w_pc4[31:28], r_ir[25:0], 2'b00};
        default: ;
      endcase
    end
  end

  // Register file: sync write, $0 never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (RegWrite && (A3 != 5'd0)) begin
      r_rf[A3] <= WD3;
    end
  end

  // Data memory: 64 words, upper address bits ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) r_dmem[i] <= '0;
    end else if (r_state == S_MEMWR) begin
      r_dmem[r_aluout[7:2]] <= r_b;
    end
  end

  assign Next_PC = r_next_pc;
  assign ALUOut  = r_aluout;
  assign B       = r_b;
  assign p_state = r_state;

endmodule

// File: tb/tb_modport_mips.sv
// Directed bench for modport_mips: runs a short hand-assembled program,
// checking write-back, branch/jump targets, cycle counts and reset.
module tb_modport_mips;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr, PC;
  logic [31:0] Next_PC, ALUResult, ALUOut, B, WD3;
  logic        zero, RegWrite;
  logic [4:0]  A3;
  logic [3:0]  p_state;

  int tests = 0;
  int fails = 0;

  // per-instruction capture
  int          cyc;
  logic [31:0] trace;
  logic        wb_seen, rw_any, bz;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd3;

  modport_mips dut (
    .clk(clk), .reset(reset), .Instr(Instr), .PC(PC), .Next_PC(Next_PC),
    .ALUResult(ALUResult), .ALUOut(ALUOut), .B(B), .zero(zero), .WD3(WD3),
    .A3(A3), .RegWrite(RegWrite), .p_state(p_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one instruction in FETCH and steps until back in FETCH.
  task automatic exec(input logic [31:0] ins, input logic [31:0] pc);
    Instr   = ins;
    PC      = pc;
    cyc     = 0;
    trace   = '0;
    wb_seen = 1'b0;
    rw_any  = 1'b0;
    bz      = 1'b0;
    wb_a3   = '0;
    wb_wd3  = '0;
    do begin
      trace = {trace[27:0], p_state};
      if (RegWrite) begin
        wb_seen = 1'b1;
        wb_a3   = A3;
        wb_wd3  = WD3;
      end
      rw_any = rw_any | RegWrite;
      if (p_state == 4'd8) bz = zero;
      tick();
      cyc++;
    end while (p_state != 4'd0 && cyc < 10);
  endtask

  initial begin
    reset = 1'b1;
    Instr = '0;
    PC    = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_state",  {28'd0, p_state}, 32'd0);
    check("rst_nextpc", Next_PC, 32'd0);
    check("rst_aluout", ALUOut, 32'd0);
    check("rst_b",      B, 32'd0);
    check("rst_rw",     {31'd0, RegWrite}, 32'd0);

    // addi $1,$0,5
    exec(32'h20010005, 32'h0);
    check("addi1_cyc", cyc, 32'd4);
    check("addi1_a3",  {27'd0, wb_a3}, 32'd1);
    check("addi1_wd3", wb_wd3, 32'd5);
    check("addi1_npc", Next_PC, 32'h4);
    // addi $2,$0,3
    exec(32'h20020003, 32'h4);
    check("addi2_a3",  {27'd0, wb_a3}, 32'd2);
    check("addi2_wd3", wb_wd3, 32'd3);
    check("addi2_npc", Next_PC, 32'h8);
    // add $3,$1,$2
    exec(32'h00221820, 32'h8);
    check("add_cyc", cyc, 32'd4);
    check("add_a3",  {27'd0, wb_a3}, 32'd3);
    check("add_wd3", wb_wd3, 32'd8);
    check("add_b",   B, 32'd3);
    // slt $4,$2,$1 : 3 < 5
    exec(32'h0041202A, 32'hC);
    check("slt_a3",  {27'd0, wb_a3}, 32'd4);
    check("slt_wd3", wb_wd3, 32'd1);
    // beq $1,$1,+2 at 0x10 : taken
    exec(32'h10210002, 32'h10);
    check("beqt_cyc",  cyc, 32'd3);
    check("beqt_zero", {31'd0, bz}, 32'd1);
    check("beqt_npc",  Next_PC, 32'h1C);
    check("beqt_rw",   {31'd0, rw_any}, 32'd0);
    // beq $1,$2,+2 at 0x10 : not taken
    exec(32'h10220002, 32'h10);
    check("beqn_zero", {31'd0, bz}, 32'd0);
    check("beqn_npc",  Next_PC, 32'h14);
    // sub $5,$2,$1 : 3 - 5
    exec(32'h00412822, 32'h14);
    check("sub_a3",  {27'd0, wb_a3}, 32'd5);
    check("sub_wd3", wb_wd3, 32'hFFFFFFFE);
    // sw $1,4($0)
    exec(32'hAC010004, 32'h18);
    check("sw_cyc", cyc, 32'd4);
    check("sw_rw",  {31'd0, rw_any}, 32'd0);
    // lw $6,4($0)
    exec(32'h8C060004, 32'h1C);
    check("lw_cyc",   cyc, 32'd5);
    check("lw_trace", trace, 32'h00001234);
    check("lw_a3",    {27'd0, wb_a3}, 32'd6);
    check("lw_wd3",   wb_wd3, 32'd5);
    // j 0x40 at 0x20
    exec(32'h08000040, 32'h20);
    check("j_cyc",   cyc, 32'd3);
    check("j_trace", trace, 32'h000001B);
    check("j_npc",   Next_PC, 32'h100);
    // undefined opcode
    exec(32'hFC000000, 32'h100);
    check("undef_cyc",   cyc, 32'd2);
    check("undef_trace", trace, 32'h00000001);
    check("undef_rw",    {31'd0, rw_any}, 32'd0);
    check("undef_npc",   Next_PC, 32'h104);
    // addi $0,$0,7 then addi $8,$0,1 : $0 must still read 0
    exec(32'h20000007, 32'h104);
    exec(32'h20080001, 32'h108);
    check("r0_a3",  {27'd0, wb_a3}, 32'd8);
    check("r0_wd3", wb_wd3, 32'd1);

    // reset in the middle of add $3,$1,$2
    Instr = 32'h00221820;
    PC    = 32'h10C;
    tick();
    tick();
    check("mid_state", {28'd0, p_state}, 32'd6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_state",  {28'd0, p_state}, 32'd0);
    check("mrst_aluout", ALUOut, 32'd0);
    check("mrst_b",      B, 32'd0);
    check("mrst_npc",    Next_PC, 32'd0);
    check("mrst_rw",     {31'd0, RegWrite}, 32'd0);
    // register file and data memory cleared by reset
    exec(32'h00221820, 32'h0);
    check("post_add_wd3", wb_wd3, 32'd0);
    check("post_add_seen", {31'd0, wb_seen}, 32'd1);
    exec(32'h8C060004, 32'h4);
    check("post_lw_wd3", wb_wd3, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
